// File: rtl/i2c_pkg.sv
// Shared types and helpers for the queued I2C write sequencer.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BYTE,
        ST_WAIT,
        ST_STOP
    } state_t;

    localparam int MAX_BYTES_LIMIT = 8;

    function automatic int len_width(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    // Byte idx of a len-byte payload, first byte in the most significant slot.
    function automatic logic [7:0] byte_sel(input logic [8*MAX_BYTES_LIMIT-1:0] data,
                                            input logic [3:0] len,
                                            input logic [3:0] idx);
        logic [8*MAX_BYTES_LIMIT-1:0] sh;
        int                           amt;
        amt = 8 * (int'(len) - int'(idx) - 1);
        sh  = data >> amt;
        return sh[7:0];
    endfunction

endpackage

// File: rtl/i2c_req_fifo.sv
// Synchronous request FIFO with registered read data and occupancy count.
module i2c_req_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_rdata;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_rdata;

    // A full FIFO refuses the write even if a pop happens in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_rdata <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rdata <= r_mem[r_rptr];
                r_rptr  <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/i2c_write_queue.sv
// Queued I2C write sequencer: buffers host write strobes and replays each as
// single-byte write commands to the I2C master, with missed-ACK abort.
module i2c_write_queue
    import i2c_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int MAX_BYTES = 4,
    localparam int LW        = len_width(MAX_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [6:0]             req_addr,
    input  logic [LW-1:0]          req_len,
    input  logic [8*MAX_BYTES-1:0] req_data,
    output logic [6:0]             cmd_address,
    output logic                   cmd_start,
    output logic                   cmd_read,
    output logic                   cmd_write,
    output logic                   cmd_write_multiple,
    output logic                   cmd_stop,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [7:0]             data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   data_out_last,
    input  logic                   missed_ack,
    input  logic                   err_clear,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   nack_err,
    output logic                   len_err
);

    localparam int EW = 7 + LW + 8*MAX_BYTES;

    state_t                 r_state;
    logic [6:0]             r_addr;
    logic [LW-1:0]          r_len;
    logic [8*MAX_BYTES-1:0] r_data;
    logic [LW-1:0]          r_idx;
    logic                   r_abort;
    logic [6:0]             r_cmd_address;
    logic                   r_cmd_start;
    logic                   r_cmd_write;
    logic                   r_cmd_stop;
    logic                   r_cmd_valid;
    logic [7:0]             r_data_out;
    logic                   r_data_valid;
    logic                   r_overflow;
    logic                   r_nack_err;
    logic                   r_len_err;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_len_ok;
    logic                   w_push;
    logic                   w_pop;
    logic [EW-1:0]          w_rdata;
    logic [6:0]             w_f_addr;
    logic [LW-1:0]          w_f_len;
    logic [8*MAX_BYTES-1:0] w_f_data;
    logic [LW-1:0]          w_idx_nxt;
    logic                   w_wait_done;
    logic                   w_abort;

    assign w_len_ok = (req_len != '0) && (req_len <= LW'(MAX_BYTES));
    assign w_push   = req_valid & ~w_full & w_len_ok;
    assign w_pop    = (r_state == ST_IDLE) & ~w_empty;

    i2c_req_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({req_addr, req_len, req_data}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign {w_f_addr, w_f_len, w_f_data} = w_rdata;

    assign w_idx_nxt   = r_idx + LW'(1);
    assign w_wait_done = (~r_cmd_valid | cmd_ready) & (~r_data_valid | data_out_ready);
    // A missed ACK in the completing cycle still counts.
    assign w_abort     = r_abort | missed_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_data        <= '0;
            r_idx         <= '0;
            r_abort       <= 1'b0;
            r_cmd_address <= '0;
            r_cmd_start   <= 1'b0;
            r_cmd_write   <= 1'b0;
            r_cmd_stop    <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_overflow    <= 1'b0;
            r_nack_err    <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            // Clear first so a same-cycle flag event below takes precedence.
            if (err_clear) begin
                r_overflow <= 1'b0;
                r_nack_err <= 1'b0;
                r_len_err  <= 1'b0;
            end
            if (req_valid & w_full)    r_overflow <= 1'b1;
            if (req_valid & ~w_len_ok) r_len_err  <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_abort <= 1'b0;
                    if (!w_empty) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_addr        <= w_f_addr;
                    r_len         <= w_f_len;
                    r_data        <= w_f_data;
                    r_idx         <= '0;
                    r_cmd_address <= w_f_addr;
                    r_cmd_start   <= 1'b1;
                    r_cmd_write   <= 1'b1;
                    r_cmd_stop    <= (w_f_len == LW'(1));
                    r_data_out    <= byte_sel(64'(w_f_data), 4'(w_f_len), 4'd0);
                    r_cmd_valid   <= 1'b1;
                    r_data_valid  <= 1'b1;
                    r_state       <= ST_BYTE;
                end
                ST_BYTE: begin
                    if (cmd_ready)      r_cmd_valid  <= 1'b0;
                    if (data_out_ready) r_data_valid <= 1'b0;
                    if (missed_ack)     r_abort      <= 1'b1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cmd_ready)      r_cmd_valid  <= 1'b0;
                    if (data_out_ready) r_data_valid <= 1'b0;
                    if (missed_ack)     r_abort      <= 1'b1;
                    if (w_wait_done) begin
                        if (w_abort) begin
                            r_nack_err <= 1'b1;
                            if (r_cmd_stop) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_cmd_start <= 1'b0;
                                r_cmd_write <= 1'b0;
                                r_cmd_stop  <= 1'b1;
                                r_cmd_valid <= 1'b1;
                                r_state     <= ST_STOP;
                            end
                        end else if (r_idx == r_len - LW'(1)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx        <= w_idx_nxt;
                            r_cmd_start  <= 1'b0;
                            r_cmd_stop   <= (w_idx_nxt == r_len - LW'(1));
                            r_data_out   <= byte_sel(64'(r_data), 4'(r_len), 4'(w_idx_nxt));
                            r_cmd_valid  <= 1'b1;
                            r_data_valid <= 1'b1;
                            r_state      <= ST_BYTE;
                        end
                    end
                end
                ST_STOP: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_stop  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready          = ~w_full;
    assign busy               = (r_state != ST_IDLE) | ~w_empty;
    assign cmd_address        = r_cmd_address;
    assign cmd_start          = r_cmd_start;
    assign cmd_write          = r_cmd_write;
    assign cmd_stop           = r_cmd_stop;
    assign cmd_valid          = r_cmd_valid;
    assign cmd_read           = 1'b0;
    assign cmd_write_multiple = 1'b0;
    assign data_out           = r_data_out;
    assign data_out_valid     = r_data_valid;
    assign data_out_last      = 1'b1;
    assign overflow           = r_overflow;
    assign nack_err           = r_nack_err;
    assign len_err            = r_len_err;

endmodule
